// File: rtl/led_chaser_clkdiv.sv
// led_chaser_clkdiv: a programmable clock divider that drives a ping-pong LED chaser.
// The divider produces a square wave whose half-period is div_count clocks.
// The chaser moves one lit LED one position on every rising transition of that wave.
// All outputs come straight from flops, so nothing depends combinationally on div_count.
module led_chaser_clkdiv #(
  parameter int CNT_WIDTH = 32,
  parameter int LED_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CNT_WIDTH-1:0] div_count,
  output logic                 outclk,
  output logic                 outclk_not,
  output logic [LED_WIDTH-1:0] LED_8
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [LED_WIDTH-1:0] LED_LSB = LED_WIDTH'(1);
  localparam logic [LED_WIDTH-1:0] LED_MSB = {1'b1, {(LED_WIDTH-1){1'b0}}};

  logic [CNT_WIDTH-1:0] counter_q, counter_d;
  logic                 outclk_q, outclk_d;
  logic                 outclk_not_q, outclk_not_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  dir_e                 dir_q, dir_d;
  logic                 toggle;
  logic                 step;

  // True when exactly one bit of the pattern is set.
  function automatic logic is_onehot(input logic [LED_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - LED_WIDTH'(1))) == '0);
  endfunction

  // Divider next state. A zero half-period freezes the divider. The >= compare
  // means a shrinking div_count takes effect at once, and the counter can never run away.
  always_comb begin
    counter_d = counter_q;
    toggle    = 1'b0;
    if (div_count == '0) begin
      counter_d = '0;
    end else if (counter_q >= (div_count - CNT_WIDTH'(1))) begin
      counter_d = '0;
      toggle    = 1'b1;
    end else begin
      counter_d = counter_q + CNT_WIDTH'(1);
    end
    outclk_d     = outclk_q ^ toggle;
    outclk_not_d = ~outclk_d;
  end

  // Step strobe: one clock wide, on the edge where outclk goes from 0 to 1.
  assign step = toggle & ~outclk_q;

  // Chaser next state. It bounces between the ends, so each endpoint appears once per pass.
  // A corrupted pattern is replaced by the reset pattern on the next step.
  always_comb begin
    led_d = led_q;
    dir_d = dir_q;
    if (step) begin
      if (!is_onehot(led_q)) begin
        led_d = LED_LSB;
        dir_d = DIR_UP;
      end else if (dir_q == DIR_UP) begin
        led_d = led_q << 1;
        if (led_d == LED_MSB) begin
          dir_d = DIR_DOWN;
        end
      end else begin
        led_d = led_q >> 1;
        if (led_d == LED_LSB) begin
          dir_d = DIR_UP;
        end
      end
    end
  end

  // State registers. The asynchronous reset returns everything to its start values immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter_q    <= '0;
      outclk_q     <= 1'b0;
      outclk_not_q <= 1'b1;
      led_q        <= LED_LSB;
      dir_q        <= DIR_UP;
    end else begin
      counter_q    <= counter_d;
      outclk_q     <= outclk_d;
      outclk_not_q <= outclk_not_d;
      led_q        <= led_d;
      dir_q        <= dir_d;
    end
  end

  assign outclk     = outclk_q;
  assign outclk_not = outclk_not_q;
  assign LED_8      = led_q;

endmodule

// File: tb/tb_led_chaser_clkdiv.sv
// Directed bench for led_chaser_clkdiv: a table of per-clock vectors plus
// hand-written sequences for async reset and the full bounce at div_count=1.
module tb_led_chaser_clkdiv;

  logic        clock;
  logic        reset;
  logic [31:0] div_count;
  logic        outclk;
  logic        outclk_not;
  logic [7:0]  LED_8;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] div;
    logic        oc;
    logic [7:0]  led;
  } vec_t;

  vec_t        vecs [26];
  logic [7:0]  bounce [15];

  led_chaser_clkdiv #(
    .CNT_WIDTH(32),
    .LED_WIDTH(8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .div_count (div_count),
    .outclk    (outclk),
    .outclk_not(outclk_not),
    .LED_8     (LED_8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic oc, input logic [7:0] led);
    check({tag, " outclk"}, {31'd0, outclk}, {31'd0, oc});
    check({tag, " outclk_not"}, {31'd0, outclk_not}, {31'd0, ~oc});
    check({tag, " LED_8"}, {24'd0, LED_8}, {24'd0, led});
  endtask

  initial begin
    // {div_count for this clock, expected outclk, expected LED_8} after the edge
    vecs[0]  = '{32'd2, 1'b0, 8'h01};  // counter 0->1
    vecs[1]  = '{32'd2, 1'b1, 8'h02};  // first rise after 2 clocks
    vecs[2]  = '{32'd2, 1'b1, 8'h02};
    vecs[3]  = '{32'd2, 1'b0, 8'h02};
    vecs[4]  = '{32'd2, 1'b0, 8'h02};  // counter now 1
    vecs[5]  = '{32'd1, 1'b1, 8'h04};  // 2->1: toggles immediately
    vecs[6]  = '{32'd1, 1'b0, 8'h04};
    vecs[7]  = '{32'd1, 1'b1, 8'h08};
    vecs[8]  = '{32'd1, 1'b0, 8'h08};
    vecs[9]  = '{32'd0, 1'b0, 8'h08};  // frozen
    vecs[10] = '{32'd0, 1'b0, 8'h08};
    vecs[11] = '{32'd0, 1'b0, 8'h08};
    vecs[12] = '{32'd3, 1'b0, 8'h08};  // resume, half-period 3
    vecs[13] = '{32'd3, 1'b0, 8'h08};
    vecs[14] = '{32'd3, 1'b1, 8'h10};
    vecs[15] = '{32'd3, 1'b1, 8'h10};
    vecs[16] = '{32'd3, 1'b1, 8'h10};
    vecs[17] = '{32'd3, 1'b0, 8'h10};
    vecs[18] = '{32'd3, 1'b0, 8'h10};  // counter 1
    vecs[19] = '{32'd5, 1'b0, 8'h10};  // increase extends the half-period
    vecs[20] = '{32'd5, 1'b0, 8'h10};
    vecs[21] = '{32'd5, 1'b0, 8'h10};
    vecs[22] = '{32'd5, 1'b1, 8'h20};
    vecs[23] = '{32'd5, 1'b1, 8'h20};
    vecs[24] = '{32'd5, 1'b1, 8'h20};  // counter 2
    vecs[25] = '{32'd2, 1'b0, 8'h20};  // decrease below counter: toggles now

    bounce = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
               8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    // Reset held with the clock running: outputs stay at reset values.
    reset     = 1'b0;
    div_count = 32'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outputs($sformatf("reset_hold%0d", i), 1'b0, 8'h01);
    end

    // Release between edges, then walk the vector table.
    #2 reset = 1'b1;
    for (int i = 0; i < 26; i++) begin
      div_count = vecs[i].div;
      tick();
      check_outputs($sformatf("vec%0d", i), vecs[i].oc, vecs[i].led);
    end

    // Asynchronous reset between edges while LED_8 is 0x20.
    check("pre_async LED_8", {24'd0, LED_8}, 32'h20);
    #2 reset = 1'b0;
    #1;
    check_outputs("async_reset", 1'b0, 8'h01);

    // Full bounce at div_count=1: outclk rises on every odd clock.
    div_count = 32'd1;
    #1 reset = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      check_outputs($sformatf("bounce%0d", i), (i % 2) == 1, bounce[(i - 1) / 2]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
